access_sequencer: RTL and testbench
===================================

ACCESS_SEQUENCER -- requirements
Module: access_sequencer

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, RAM clock-to-q read latency in cycles (legal 1..3).
REQ-002 SHALL have ports: clock  input  1  rising-edge system clock.
REQ-003 SHALL have: resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have: start  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have: protocol  input  3  request protocol code (001, 010, 101, 110 legal).
REQ-006 SHALL have: access_p2  input  1  0 = player 1 record, 1 = player 2 record.
REQ-007 SHALL have: access_type  input  2  01 = public key, 10 = net money; 00/11 illegal.
REQ-008 SHALL have: wren  input  1  1 = write request, 0 = read request.
REQ-009 SHALL have: data_in  input  8  write data.
REQ-010 SHALL have: ram_address  output  3  RAM word address.
REQ-011 SHALL have: ram_data  output  8  RAM write data.
REQ-012 SHALL have: ram_wren  output  1  RAM write enable.
REQ-013 SHALL have: ram_q  input  8  RAM read data.
REQ-014 SHALL have: busy  output  1  high from request acceptance until done.
REQ-015 SHALL have: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have: error  output  1  valid with done; illegal request.
REQ-017 SHALL have: result  output  8  read data, held until next done.
REQ-018 SHALL have: result_protocol  output  3  protocol of last completed request, held until next done.

Function
REQ-019 SHALL use FSM states IDLE, LATCH, WAIT, WRITE, DONE.
REQ-020 In IDLE with start=1, SHALL register protocol, access_p2, access_type, wren, data_in and go to LATCH next cycle; busy rises that same edge.
REQ-021 LATCH SHALL drive ram_address = {access_p2, access_type} from registered fields; if access_type is 00 or 11 or protocol illegal, SHALL set error and go to DONE without RAM access.
REQ-022 LATCH with registered wren=1 SHALL go to WRITE; WRITE SHALL assert ram_wren and ram_data = registered data_in for exactly one cycle, then DONE.
REQ-023 LATCH with wren=0 SHALL go to WAIT; WAIT SHALL count READ_LATENCY cycles holding ram_address, then capture ram_q into result and go to DONE.
REQ-024 Read latency start-to-done SHALL be READ_LATENCY+3 cycles; write SHALL be 3 cycles; illegal SHALL be 2 cycles.
REQ-025 DONE SHALL pulse done for one cycle, load result_protocol, deassert busy, return to IDLE.
REQ-026 start while busy SHALL be ignored (no queuing); start in the DONE cycle SHALL also be ignored.
REQ-027 result SHALL be unchanged on writes and errors; error SHALL be 0 on successful completions.
REQ-028 ram_wren SHALL never be asserted outside WRITE; ram_address SHALL be stable throughout WAIT.
REQ-029 Wait counter SHALL be 2 bits, cleared on entry to WAIT, no wrap beyond READ_LATENCY.

Reset
REQ-030 resetn=0 SHALL immediately force IDLE, busy=0, done=0, error=0, ram_wren=0, ram_address=0, ram_data=0, result=0, result_protocol=0.
REQ-031 Reset mid-WRITE SHALL drop ram_wren asynchronously; no done pulse SHALL follow the aborted request.
REQ-032 First start SHALL be honoured on the first rising edge after resetn deasserts.

Structure
REQ-033 Shared package SHALL hold state encodings, protocol codes (001, 010, 101, 110), access_type codes (01 key, 10 money) and the address-map rule.
REQ-034 Wait counter MAY be a sub-module latency_counter; all else stays in access_sequencer.

Verification
REQ-035 Read: RAM addr 6 = 8'h5A, start with protocol 110, access_p2=1, access_type 10, wren=0 -> ram_address 3'b110, done 5 cycles after start, result 8'h5A, result_protocol 110, error 0.
REQ-036 Write: protocol 001, access_p2=0, access_type 10, wren=1, data_in 8'h37 -> ram_wren high exactly one cycle, ram_address 3'b010, ram_data 8'h37, done 3 cycles after start, result unchanged.
REQ-037 Illegal: access_type 00 -> no ram_wren, done 2 cycles after start with error=1; then access_type 11 with protocol 011 -> same.
REQ-038 Overlap: second start every cycle during a read -> exactly one done; result from first request only.
REQ-039 Reset: assert resetn=0 during WRITE -> ram_wren and busy drop same cycle, no done; a following read completes normally.
REQ-040 Parameter: READ_LATENCY=1 and 3 -> read done at 4 and 6 cycles after start, correct ram_q captured.

Source files
------------

// File: rtl/access_sequencer_pkg.sv
// Shared types, code points and address-map helpers for the player-record access sequencer.
package access_sequencer_pkg;

   localparam int unsigned ADDR_W  = 3;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PROTO_W = 3;
   localparam int unsigned ACC_W   = 2;
   localparam int unsigned CNT_W   = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [PROTO_W-1:0] PROTO_001 = 3'b001;
   localparam logic [PROTO_W-1:0] PROTO_010 = 3'b010;
   localparam logic [PROTO_W-1:0] PROTO_101 = 3'b101;
   localparam logic [PROTO_W-1:0] PROTO_110 = 3'b110;

   localparam logic [ACC_W-1:0] ACC_KEY   = 2'b01;
   localparam logic [ACC_W-1:0] ACC_MONEY = 2'b10;

   // Request fields captured when a start is accepted.
   typedef struct packed {
      logic [PROTO_W-1:0] protocol;
      logic [ACC_W-1:0]   access_type;
      logic               wren;
      logic [DATA_W-1:0]  data;
   } req_t;

   function automatic logic proto_legal(input logic [PROTO_W-1:0] p);
      return (p == PROTO_001) || (p == PROTO_010) || (p == PROTO_101) || (p == PROTO_110);
   endfunction

   function automatic logic access_legal(input logic [ACC_W-1:0] t);
      return (t == ACC_KEY) || (t == ACC_MONEY);
   endfunction

   function automatic logic req_legal(input req_t r);
      return proto_legal(r.protocol) && access_legal(r.access_type);
   endfunction

   // Word address: player select on top, record type below.
   function automatic logic [ADDR_W-1:0] map_address(input logic p2, input logic [ACC_W-1:0] t);
      return {p2, t};
   endfunction

endpackage

// File: rtl/access_sequencer_latency_counter.sv
// Saturating read-latency counter; cleared on WAIT entry, stops at LIMIT.
module access_sequencer_latency_counter
   import access_sequencer_pkg::*;
#(
   parameter int unsigned LIMIT = 2
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             expired_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired_c = (count == LAST);

endmodule

// File: rtl/access_sequencer.sv
// Sequences one player-record RAM read or write per accepted start, with legality checking.
module access_sequencer
   import access_sequencer_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic [PROTO_W-1:0] protocol,
   input  logic               access_p2,
   input  logic [ACC_W-1:0]   access_type,
   input  logic               wren,
   input  logic [DATA_W-1:0]  data_in,
   output logic [ADDR_W-1:0]  ram_address,
   output logic [DATA_W-1:0]  ram_data,
   output logic               ram_wren,
   input  logic [DATA_W-1:0]  ram_q,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [DATA_W-1:0]  result,
   output logic [PROTO_W-1:0] result_protocol
);

   state_t           state;
   req_t             req;
   logic [CNT_W-1:0] wait_count;
   logic             wait_clear_c;
   logic             wait_en_c;
   logic             wait_expired_c;

   assign wait_clear_c = (state == LATCH);
   assign wait_en_c    = (state == WAIT);

   // Extra WAIT cycle beyond READ_LATENCY gives ram_q a full cycle of margin before capture.
   access_sequencer_latency_counter #(
      .LIMIT (READ_LATENCY)
   ) u_latency_counter (
      .clock     (clock),
      .resetn    (resetn),
      .clear     (wait_clear_c),
      .enable    (wait_en_c),
      .count     (wait_count),
      .expired_c (wait_expired_c)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state           <= IDLE;
         req             <= '0;
         ram_address     <= '0;
         ram_data        <= '0;
         ram_wren        <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         result          <= '0;
         result_protocol <= '0;
      end else begin
         done     <= 1'b0;
         error    <= 1'b0;
         ram_wren <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  req.protocol    <= protocol;
                  req.access_type <= access_type;
                  req.wren        <= wren;
                  req.data        <= data_in;
                  ram_address     <= map_address(access_p2, access_type);
                  busy            <= 1'b1;
                  state           <= LATCH;
               end
            end
            LATCH: begin
               if (!req_legal(req)) begin
                  error           <= 1'b1;
                  done            <= 1'b1;
                  result_protocol <= req.protocol;
                  state           <= DONE;
               end else if (req.wren) begin
                  ram_wren <= 1'b1;
                  ram_data <= req.data;
                  state    <= WRITE;
               end else begin
                  state <= WAIT;
               end
            end
            WRITE: begin
               done            <= 1'b1;
               result_protocol <= req.protocol;
               state           <= DONE;
            end
            WAIT: begin
               if (wait_expired_c) begin
                  result          <= ram_q;
                  done            <= 1'b1;
                  result_protocol <= req.protocol;
                  state           <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   logic unused_c;
   assign unused_c = ^wait_count;

endmodule

// File: tb/tb_access_sequencer.sv
// Directed bench: three sequencers (READ_LATENCY 1, 2, 3) share stimulus, each with its own RAM model.
module tb_access_sequencer;

   logic       clock;
   logic       resetn;
   logic       start;
   logic [2:0] protocol;
   logic       access_p2;
   logic [1:0] access_type;
   logic       wren;
   logic [7:0] data_in;

   logic [2:0] ram_address     [3];
   logic [7:0] ram_data        [3];
   logic       ram_wren        [3];
   logic [7:0] ram_q           [3];
   logic       busy            [3];
   logic       done            [3];
   logic       error           [3];
   logic [7:0] result          [3];
   logic [2:0] result_protocol [3];

   int checks = 0;
   int passed = 0;

   int         done_at  [3];
   int         done_cnt [3];
   logic       err_at_done;
   int         wren_cnt;
   logic [2:0] wren_addr;
   logic [7:0] wren_data;
   logic [2:0] addr_seen;
   logic       busy_k1;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bit   [7:0] mem  [8];
      logic [7:0] pipe [3];

      access_sequencer #(
         .READ_LATENCY (g + 1)
      ) u_dut (
         .clock           (clock),
         .resetn          (resetn),
         .start           (start),
         .protocol        (protocol),
         .access_p2       (access_p2),
         .access_type     (access_type),
         .wren            (wren),
         .data_in         (data_in),
         .ram_address     (ram_address[g]),
         .ram_data        (ram_data[g]),
         .ram_wren        (ram_wren[g]),
         .ram_q           (ram_q[g]),
         .busy            (busy[g]),
         .done            (done[g]),
         .error           (error[g]),
         .result          (result[g]),
         .result_protocol (result_protocol[g])
      );

      // RAM with g+1 cycles of clock-to-q read latency.
      always @(posedge clock) begin
         if (ram_wren[g] === 1'b1) mem[ram_address[g]] <= ram_data[g];
         pipe[0] <= mem[ram_address[g]];
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign ram_q[g] = pipe[g];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Caller is at a negedge; start is raised here and the next 14 cycles are observed.
   task automatic run_req(input logic [2:0] p, input logic p2, input logic [1:0] t,
                          input logic w, input logic [7:0] d, input bit hold);
      protocol    = p;
      access_p2   = p2;
      access_type = t;
      wren        = w;
      data_in     = d;
      start       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         done_at[i]  = 0;
         done_cnt[i] = 0;
      end
      err_at_done = 1'bx;
      wren_cnt    = 0;
      wren_addr   = '0;
      wren_data   = '0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         if (k == 1) begin
            addr_seen = ram_address[1];
            busy_k1   = busy[1];
            if (hold) begin
               protocol    = 3'b011;
               access_type = 2'b11;
               wren        = 1'b1;
               data_in     = 8'hFF;
            end else begin
               start = 1'b0;
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
               done_cnt[i]++;
               if (done_at[i] == 0) done_at[i] = k;
               if (i == 1) err_at_done = error[1];
            end
         end
         if (ram_wren[1] === 1'b1) begin
            wren_cnt++;
            wren_addr = ram_address[1];
            wren_data = ram_data[1];
         end
         if (hold && done_at[1] != 0 && k == done_at[1] + 1) start = 1'b0;
      end
      start = 1'b0;
   endtask

   initial begin
      resetn      = 1'b0;
      start       = 1'b0;
      protocol    = '0;
      access_p2   = 1'b0;
      access_type = '0;
      wren        = 1'b0;
      data_in     = '0;
      repeat (3) @(negedge clock);
      check("reset_outputs", 32'({busy[1], done[1], error[1], ram_wren[1], ram_address[1],
                                  ram_data[1], result[1], result_protocol[1]}), 32'd0);

      // Preload addr 6 with 5A; start coincides with reset release.
      resetn = 1'b1;
      run_req(3'b110, 1'b1, 2'b10, 1'b1, 8'h5A, 1'b0);
      check("wr6_busy_after_accept", 32'(busy_k1), 32'd1);
      check("wr6_done_cycle", 32'(done_at[1]), 32'd3);
      check("wr6_done_count", 32'(done_cnt[1]), 32'd1);
      check("wr6_wren_cycles", 32'(wren_cnt), 32'd1);
      check("wr6_addr", 32'(wren_addr), 32'h6);
      check("wr6_data", 32'(wren_data), 32'h5A);
      check("wr6_result_kept", 32'(result[1]), 32'h00);
      check("wr6_error", 32'(err_at_done), 32'd0);
      check("wr6_result_protocol", 32'(result_protocol[1]), 32'h6);

      // Read addr 6 at all three latencies.
      run_req(3'b110, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0);
      check("rd6_addr", 32'(addr_seen), 32'h6);
      check("rd6_done_lat1", 32'(done_at[0]), 32'd4);
      check("rd6_done_lat2", 32'(done_at[1]), 32'd5);
      check("rd6_done_lat3", 32'(done_at[2]), 32'd6);
      check("rd6_result_lat1", 32'(result[0]), 32'h5A);
      check("rd6_result_lat2", 32'(result[1]), 32'h5A);
      check("rd6_result_lat3", 32'(result[2]), 32'h5A);
      check("rd6_result_protocol", 32'(result_protocol[1]), 32'h6);
      check("rd6_error", 32'(err_at_done), 32'd0);
      check("rd6_no_wren", 32'(wren_cnt), 32'd0);

      run_req(3'b001, 1'b0, 2'b10, 1'b1, 8'h37, 1'b0);
      check("wr2_done_cycle", 32'(done_at[1]), 32'd3);
      check("wr2_wren_cycles", 32'(wren_cnt), 32'd1);
      check("wr2_addr", 32'(wren_addr), 32'h2);
      check("wr2_data", 32'(wren_data), 32'h37);
      check("wr2_result_kept", 32'(result[1]), 32'h5A);
      check("wr2_result_protocol", 32'(result_protocol[1]), 32'h1);

      run_req(3'b001, 1'b0, 2'b00, 1'b1, 8'hAA, 1'b0);
      check("ill00_done_cycle", 32'(done_at[1]), 32'd2);
      check("ill00_error", 32'(err_at_done), 32'd1);
      check("ill00_no_wren", 32'(wren_cnt), 32'd0);
      check("ill00_result_kept", 32'(result[1]), 32'h5A);

      run_req(3'b011, 1'b1, 2'b11, 1'b0, 8'h00, 1'b0);
      check("ill11_done_cycle", 32'(done_at[1]), 32'd2);
      check("ill11_error", 32'(err_at_done), 32'd1);
      check("ill11_result_protocol", 32'(result_protocol[1]), 32'h3);

      run_req(3'b100, 1'b0, 2'b01, 1'b1, 8'h11, 1'b0);
      check("illproto_done_cycle", 32'(done_at[1]), 32'd2);
      check("illproto_error", 32'(err_at_done), 32'd1);
      check("illproto_no_wren", 32'(wren_cnt), 32'd0);

      run_req(3'b101, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
      check("rd2_done_cycle", 32'(done_at[1]), 32'd5);
      check("rd2_result_lat1", 32'(result[0]), 32'h37);
      check("rd2_result_lat2", 32'(result[1]), 32'h37);
      check("rd2_result_lat3", 32'(result[2]), 32'h37);
      check("rd2_result_protocol", 32'(result_protocol[1]), 32'h5);
      check("rd2_error", 32'(err_at_done), 32'd0);

      // Start held high through a read (and its DONE cycle).
      run_req(3'b010, 1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
      check("ovl_done_count", 32'(done_cnt[1]), 32'd1);
      check("ovl_done_cycle", 32'(done_at[1]), 32'd5);
      check("ovl_result", 32'(result[1]), 32'h5A);
      check("ovl_result_protocol", 32'(result_protocol[1]), 32'h2);
      check("ovl_error", 32'(err_at_done), 32'd0);
      check("ovl_all_idle", 32'({busy[0], busy[1], busy[2]}), 32'd0);

      // Reset in the WRITE cycle of a write to addr 5.
      protocol    = 3'b010;
      access_p2   = 1'b1;
      access_type = 2'b01;
      wren        = 1'b1;
      data_in     = 8'hC3;
      start       = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check("rst_wren_in_write", 32'(ram_wren[1]), 32'd1);
      #1 resetn = 1'b0;
      #1;
      check("rst_async_drop", 32'({busy[0], busy[1], busy[2], ram_wren[0], ram_wren[1],
                                   ram_wren[2], ram_address[1], ram_data[1]}), 32'd0);
      @(negedge clock);
      check("rst_no_done", 32'({done[0], done[1], done[2]}), 32'd0);
      resetn = 1'b1;
      run_req(3'b101, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0);
      check("post_rst_done_count", 32'(done_cnt[1]), 32'd1);
      check("post_rst_done_cycle", 32'(done_at[1]), 32'd5);
      check("post_rst_result", 32'(result[1]), 32'h5A);
      run_req(3'b101, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0);
      check("aborted_write_absent", 32'(result[1]), 32'h00);
      check("aborted_rd_done_cycle", 32'(done_at[1]), 32'd5);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
